// File: rtl/mouse_trackball_pulser_if.sv
// Bus bundle for mouse_trackball_pulser: PS/2 packet and controls in, per-axis dir/step out.
// The joystick member exists only when MTB_JOY_EN is defined.
// No handshake: packets are toggle-strobed, outputs are free-running levels.
interface mouse_trackball_pulser_if;
    logic [24:0] ps2_mouse;
    logic [1:0]  mouse_speed;
    logic        flip;
`ifdef MTB_JOY_EN
    logic [3:0]  joystick;
`endif
    logic        h_dir;
    logic        h_clk;
    logic        v_dir;
    logic        v_clk;

`ifdef MTB_JOY_EN
    modport master (
        output ps2_mouse, mouse_speed, flip, joystick,
        input  h_dir, h_clk, v_dir, v_clk
    );
    modport slave (
        input  ps2_mouse, mouse_speed, flip, joystick,
        output h_dir, h_clk, v_dir, v_clk
    );
`else
    modport master (
        output ps2_mouse, mouse_speed, flip,
        input  h_dir, h_clk, v_dir, v_clk
    );
    modport slave (
        input  ps2_mouse, mouse_speed, flip,
        output h_dir, h_clk, v_dir, v_clk
    );
`endif
endinterface

// File: rtl/mouse_trackball_pulser.sv
// PS/2 mouse packets -> Missile Command trackball dir/step pulses; optional joystick input via MTB_JOY_EN.
// Latency: packet lands in the accumulator 1 cycle after the toggle is sampled; first edge <= 1.5*PULSE_DIV+2 cycles.
// Backpressure: none; excess motion saturates in the accumulator and drains at one edge per axis per slot.
module mouse_trackball_pulser #(
    parameter int ACC_W     = 12,
    parameter int PULSE_DIV = 2048
) (
    input  logic                    clk,
    input  logic                    res_n,
    mouse_trackball_pulser_if.slave mtb
);

    localparam int DIV_W = $clog2(PULSE_DIV);
    // Sum must hold acc + largest scaled packet (+/-2048) + joystick + consume without wrapping.
    localparam int SW    = (ACC_W + 2 > 14) ? ACC_W + 2 : 14;

    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(PULSE_DIV - 1);
    localparam logic [DIV_W-1:0]     DIV_HALF = DIV_W'(PULSE_DIV / 2);
    localparam logic signed [SW-1:0] ACC_MAX  = SW'((1 << (ACC_W - 1)) - 1);
    localparam logic signed [SW-1:0] ACC_MIN  = ~ACC_MAX;
    localparam logic signed [SW-1:0] STEP_Q   = SW'(4);
    localparam logic signed [SW-1:0] NSTEP_Q  = -STEP_Q;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } step_st_e;

    logic                    prev_tog_q, prev_tog_d;
    logic                    armed_q, armed_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic signed [ACC_W-1:0] acc_q [2];
    logic signed [ACC_W-1:0] acc_d [2];
    step_st_e                st_q  [2];
    step_st_e                st_d  [2];
    logic                    dir_q [2];
    logic                    dir_d [2];
    logic                    stp_q [2];
    logic                    stp_d [2];

    logic                    pkt;
    logic signed [8:0]       dx9, dy9;
    logic signed [SW-1:0]    inc  [2];
    logic signed [SW-1:0]    joy  [2];
    logic signed [SW-1:0]    base [2];
    logic signed [SW-1:0]    cons [2];
    logic signed [SW-1:0]    sum  [2];

    function automatic logic signed [SW-1:0] scale_delta(
        input logic signed [8:0] d,
        input logic [1:0]        sp,
        input logic              neg
    );
        logic signed [SW-1:0] v;
        v = SW'(d) <<< sp;
        return neg ? -v : v;
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SW-1:0] s);
        if (s > ACC_MAX) return ACC_MAX[ACC_W-1:0];
        if (s < ACC_MIN) return ACC_MIN[ACC_W-1:0];
        return s[ACC_W-1:0];
    endfunction

    // Packet detect and 9-bit delta extraction; overflow pins the delta to the extreme of its sign.
    always_comb begin
        pkt = armed_q & (mtb.ps2_mouse[24] ^ prev_tog_q);

        if (mtb.ps2_mouse[6]) dx9 = mtb.ps2_mouse[4] ? 9'h100 : 9'h0FF;
        else                  dx9 = {mtb.ps2_mouse[4], mtb.ps2_mouse[15:8]};

        if (mtb.ps2_mouse[7]) dy9 = mtb.ps2_mouse[5] ? 9'h100 : 9'h0FF;
        else                  dy9 = {mtb.ps2_mouse[5], mtb.ps2_mouse[23:16]};

        inc[0] = '0;
        inc[1] = '0;
        if (pkt) begin
            inc[0] = scale_delta(dx9, mtb.mouse_speed, mtb.flip);
            inc[1] = scale_delta(dy9, mtb.mouse_speed, mtb.flip);
        end
    end

    always_comb begin
        joy[0] = '0;
        joy[1] = '0;
`ifdef MTB_JOY_EN
        // joystick = {up, down, left, right}; opposite directions cancel.
        if (div_q == '0) begin
            joy[0] = (mtb.joystick[0] ? SW'(2) : SW'(0)) - (mtb.joystick[1] ? SW'(2) : SW'(0));
            joy[1] = (mtb.joystick[3] ? SW'(2) : SW'(0)) - (mtb.joystick[2] ? SW'(2) : SW'(0));
            if (mtb.flip) begin
                joy[0] = -joy[0];
                joy[1] = -joy[1];
            end
        end
`endif
    end

    // Axis 0 is horizontal, axis 1 vertical; both share the slot counter.
    always_comb begin
        prev_tog_d = mtb.ps2_mouse[24];
        armed_d    = 1'b1;
        div_d      = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;

        for (int a = 0; a < 2; a++) begin
            st_d[a]  = st_q[a];
            dir_d[a] = dir_q[a];
            stp_d[a] = stp_q[a];
            cons[a]  = '0;
            base[a]  = SW'(acc_q[a]) + joy[a];

            case (st_q[a])
                ST_IDLE: begin
                    if (div_q == '0) begin
                        if (base[a] >= STEP_Q) begin
                            dir_d[a] = 1'b1;
                            cons[a]  = STEP_Q;
                            st_d[a]  = ST_ARMED;
                        end else if (base[a] <= NSTEP_Q) begin
                            dir_d[a] = 1'b0;
                            cons[a]  = NSTEP_Q;
                            st_d[a]  = ST_ARMED;
                        end
                    end
                end
                ST_ARMED: begin
                    // Edge lands half a slot after dir was set, so dir has settled.
                    if (div_q == DIV_HALF) begin
                        stp_d[a] = ~stp_q[a];
                        st_d[a]  = ST_IDLE;
                    end
                end
                default: st_d[a] = ST_IDLE;
            endcase

            // A packet and a consume in the same cycle fold into one update.
            sum[a]   = base[a] + inc[a] - cons[a];
            acc_d[a] = sat_acc(sum[a]);
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            prev_tog_q <= 1'b0;
            armed_q    <= 1'b0;
            div_q      <= '0;
            for (int a = 0; a < 2; a++) begin
                acc_q[a] <= '0;
                st_q[a]  <= ST_IDLE;
                dir_q[a] <= 1'b0;
                stp_q[a] <= 1'b0;
            end
        end else begin
            prev_tog_q <= prev_tog_d;
            armed_q    <= armed_d;
            div_q      <= div_d;
            for (int a = 0; a < 2; a++) begin
                acc_q[a] <= acc_d[a];
                st_q[a]  <= st_d[a];
                dir_q[a] <= dir_d[a];
                stp_q[a] <= stp_d[a];
            end
        end
    end

    assign mtb.h_dir = dir_q[0];
    assign mtb.h_clk = stp_q[0];
    assign mtb.v_dir = dir_q[1];
    assign mtb.v_clk = stp_q[1];

endmodule

// File: tb/tb_mouse_trackball_pulser.sv
// Scoreboard bench for mouse_trackball_pulser: stimulus queues expected step edges, a monitor pops them.
module tb_mouse_trackball_pulser;
    localparam int P = 16;

    typedef struct {
        logic dir;
        int   gap;
    } exp_t;

    logic clk   = 1'b0;
    logic res_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic tog;
    exp_t hq[$];
    exp_t vq[$];

    logic ph_clk, ph_dir, pv_clk, pv_dir;
    int   h_last = 0, v_last = 0, h_chg = 0, v_chg = 0;

    mouse_trackball_pulser_if mtb();

    mouse_trackball_pulser #(.ACC_W(12), .PULSE_DIV(P)) dut (
        .clk   (clk),
        .res_n (res_n),
        .mtb   (mtb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic on_edge(input int ax, input logic dir, input int now, input int last, input int chg);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (ax == 0 && hq.size() > 0) begin e = hq.pop_front(); have = 1'b1; end
        if (ax == 1 && vq.size() > 0) begin e = vq.pop_front(); have = 1'b1; end
        checks++;
        if (!have) begin
            errors++;
            $display("FAIL unexpected_edge axis=%0d at cycle %0d dir=%0b, required no edge", ax, now, dir);
        end else begin
            if (dir !== e.dir) begin
                errors++;
                $display("FAIL edge_dir axis=%0d at cycle %0d got %0b, required %0b", ax, now, dir, e.dir);
            end
            if (e.gap != 0) begin
                checks++;
                if (now - last != e.gap) begin
                    errors++;
                    $display("FAIL edge_gap axis=%0d got %0d cycles, required %0d", ax, now - last, e.gap);
                end
            end
        end
        checks++;
        if (now - chg < P / 2) begin
            errors++;
            $display("FAIL dir_setup axis=%0d got %0d cycles, required >= %0d", ax, now - chg, P / 2);
        end
    endtask

    always @(negedge clk) begin
        if (!res_n) begin
            h_chg = cyc;
            v_chg = cyc;
        end else begin
            if (mtb.h_dir !== ph_dir) h_chg = cyc;
            if (mtb.v_dir !== pv_dir) v_chg = cyc;
            if (mtb.h_clk !== ph_clk) begin
                on_edge(0, mtb.h_dir, cyc, h_last, h_chg);
                h_last = cyc;
            end
            if (mtb.v_clk !== pv_clk) begin
                on_edge(1, mtb.v_dir, cyc, v_last, v_chg);
                v_last = cyc;
            end
        end
        ph_clk = mtb.h_clk;
        ph_dir = mtb.h_dir;
        pv_clk = mtb.v_clk;
        pv_dir = mtb.v_dir;
    end

    task automatic push(input int ax, input logic dir, input int n, input int gap);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.dir = dir;
            e.gap = (i == 0) ? 0 : gap;
            if (ax == 0) hq.push_back(e);
            else         vq.push_back(e);
        end
    endtask

    task automatic send_pkt(input logic [7:0] dx, input logic [7:0] dy, input logic [7:0] flags);
        tog = ~tog;
        mtb.ps2_mouse = {tog, dy, dx, flags};
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string name);
        logic [3:0] o;
        o = {mtb.h_dir, mtb.h_clk, mtb.v_dir, mtb.v_clk};
        checks++;
        if (o !== 4'b0000) begin
            errors++;
            $display("FAIL %s {h_dir,h_clk,v_dir,v_clk} got %b, required 0000", name, o);
        end
    endtask

    task automatic drain(input string name, input int budget);
        int k;
        k = 0;
        while ((hq.size() + vq.size()) != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if ((hq.size() + vq.size()) != 0) begin
            errors++;
            $display("FAIL %s pending edges h=%0d v=%0d after %0d cycles, required 0", name, hq.size(), vq.size(), budget);
            hq.delete();
            vq.delete();
        end
    endtask

    task automatic wait_hdir(input logic val, input int budget, input string name);
        int k;
        k = 0;
        while (mtb.h_dir !== val && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (mtb.h_dir !== val) begin
            errors++;
            $display("FAIL %s h_dir got %b, required %b within %0d cycles", name, mtb.h_dir, val, budget);
        end
    endtask

    // Called at a negedge; the offset keeps reset edges clear of the monitor's sampling instant.
    task automatic do_reset(input int n);
        #2 res_n = 1'b0;
        repeat (n) @(negedge clk);
        check_outputs_zero("reset_outputs");
        #2 res_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        tog             = 1'b1;
        mtb.ps2_mouse   = {1'b1, 24'h000000};
        mtb.mouse_speed = 2'd2;
        mtb.flip        = 1'b0;
`ifdef MTB_JOY_EN
        mtb.joystick    = 4'b0000;
`endif
        @(negedge clk);

        // Toggle high at reset release must not count as a packet.
        do_reset(3);
        idle(3 * P);
        check_outputs_zero("post_reset_idle");

        // dx=+3 at 100%: three right steps one slot apart.
        push(0, 1'b1, 3, P);
        send_pkt(8'd3, 8'd0, 8'h00);
        drain("dx3_speed2", 4 * P);
        idle(2 * P);

        // dx=+1 at 25%: a step only once four quarter-steps have built up.
        mtb.mouse_speed = 2'd0;
        for (int i = 0; i < 3; i++) send_pkt(8'd1, 8'd0, 8'h00);
        idle(3 * P);
        push(0, 1'b1, 1, 0);
        send_pkt(8'd1, 8'd0, 8'h00);
        drain("quarter_steps", 3 * P);
        idle(3 * P);

        // dy=-2 with flip at 100%: two upward vertical steps.
        mtb.mouse_speed = 2'd2;
        mtb.flip        = 1'b1;
        push(1, 1'b1, 2, P);
        send_pkt(8'd0, 8'hFE, 8'h20);
        drain("dy_flip", 4 * P);
        idle(2 * P);
        mtb.flip = 1'b0;

        // X overflow, negative, 200%: -2048. After the first consume (-2044) a second
        // identical packet saturates back to -2048, giving 1 + 512 left steps in total.
        mtb.mouse_speed = 2'd3;
        push(0, 1'b0, 513, P);
        send_pkt(8'd0, 8'd0, 8'h50);
        wait_hdir(1'b0, 2 * P, "ovf_first_consume");
        send_pkt(8'd0, 8'd0, 8'h50);
        drain("ovf_saturate", 520 * P);
        idle(3 * P);

        // Reset between dir setup and the edge: edge abandoned, remaining +4 discarded.
        mtb.mouse_speed = 2'd2;
        send_pkt(8'd2, 8'd0, 8'h00);
        wait_hdir(1'b1, 2 * P, "mid_step_setup");
        idle(P / 4);
        do_reset(2);
        idle(3 * P);
        push(0, 1'b1, 1, 0);
        send_pkt(8'd1, 8'd0, 8'h00);
        drain("after_mid_reset", 3 * P);
        idle(3 * P);

`ifdef MTB_JOY_EN
        // Right held for 8 slots: +2 per slot, one step every second slot.
        push(0, 1'b1, 4, 2 * P);
        mtb.joystick = 4'b0001;
        idle(8 * P);
        mtb.joystick = 4'b0000;
        drain("joy_right", 3 * P);
        idle(3 * P);
`endif

        drain("final_queue", 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
